// File: rtl/sq_pkg.sv
// sq_pkg -- shared constants and types for the sq register interface.
//   NCH             : number of synthesis channels
//   ADDR_*          : register address map (bank bases are 4-aligned)
//   BUSY_CYCLES_DEF : default busy window after an accepted data write
//   busy_state_e    : busy timer FSM state encoding
package sq_pkg;

  localparam int NCH = 4;

  localparam logic [7:0] ADDR_KEYON = 8'h28;
  localparam logic [7:0] ADDR_MUL   = 8'h30;
  localparam logic [7:0] ADDR_FNL   = 8'hA0;
  localparam logic [7:0] ADDR_FNH   = 8'hA4;

  localparam int BUSY_CYCLES_DEF = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } busy_state_e;

  // True when addr falls in the 4-register bank starting at base.
  function automatic logic in_bank(input logic [7:0] addr, input logic [7:0] base);
    return addr[7:2] == base[7:2];
  endfunction

endpackage

// File: rtl/sq_busy_timer.sv
// sq_busy_timer -- busy window generator.
//   clk, reset_n : clock, async active-low reset
//   start        : one-cycle pulse for an accepted data write (ignored while busy)
//   busy         : registered, high for exactly BUSY_CYCLES cycles after start
//
// state   | meaning
// --------+------------------------------------------------------
// ST_IDLE | no write in progress, start accepted
// ST_BUSY | counting down; leaves when the counter reads 1
module sq_busy_timer
  import sq_pkg::*;
#(
  parameter int BUSY_CYCLES = BUSY_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy
);

  localparam logic [7:0] CNT_LOAD = 8'(BUSY_CYCLES);

  busy_state_e state_q;
  logic [7:0]  cnt_q;
  logic        busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_BUSY;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (cnt_q == 8'd1) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/sq_regif.sv
// sq_regif -- host write port and per-channel register storage.
//   clk, reset_n   : clock, async active-low reset
//   cs_n, wr_n     : active-low chip select / write strobe (one event per strobe)
//   a0             : 0 = address write, 1 = data write
//   din            : host write data
//   dout           : status {busy, 7'b0}
//   fnumber        : 4 x 11-bit frequency numbers, channel n at [11n+10:11n]
//   block          : 4 x 3-bit octave blocks, channel n at [3n+2:3n]
//   multiple       : 4 x 4-bit multipliers, channel n at [4n+3:4n]
//   keyon          : per-channel key state
module sq_regif
  import sq_pkg::*;
#(
  parameter int BUSY_CYCLES = BUSY_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cs_n,
  input  logic               wr_n,
  input  logic               a0,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic [NCH*11-1:0]  fnumber,
  output logic [NCH*3-1:0]   block,
  output logic [NCH*4-1:0]   multiple,
  output logic [NCH-1:0]     keyon
);

  logic               act_d, act_q;
  logic               wr_evt, data_acc, busy;
  logic [7:0]         addr_q;
  logic [5:0]         fnh_q;      // {block, fnum[10:8]} held until the low-byte write
  logic [NCH*11-1:0]  fnumber_q;
  logic [NCH*3-1:0]   block_q;
  logic [NCH*4-1:0]   multiple_q;
  logic [NCH-1:0]     keyon_q;
  logic [1:0]         ch;

  assign act_d    = !cs_n && !wr_n;
  assign wr_evt   = act_d && !act_q;        // rising edge of the strobe only
  assign data_acc = wr_evt && a0 && !busy;
  assign ch       = addr_q[1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_q      <= 1'b0;
      addr_q     <= '0;
      fnh_q      <= '0;
      fnumber_q  <= '0;
      block_q    <= '0;
      multiple_q <= '0;
      keyon_q    <= '0;
    end else begin
      act_q <= act_d;
      if (wr_evt && !a0) begin
        addr_q <= din;
      end
      if (data_acc) begin
        if (in_bank(addr_q, ADDR_MUL)) begin
          multiple_q[int'(ch)*4 +: 4] <= din[3:0];
        end else if (in_bank(addr_q, ADDR_FNH)) begin
          fnh_q <= din[5:0];
        end else if (in_bank(addr_q, ADDR_FNL)) begin
          fnumber_q[int'(ch)*11 +: 11] <= {fnh_q[2:0], din};
          block_q[int'(ch)*3 +: 3]     <= fnh_q[5:3];
        end else if (addr_q == ADDR_KEYON) begin
          keyon_q[din[1:0]] <= din[4];
        end
      end
    end
  end

  sq_busy_timer #(
    .BUSY_CYCLES(BUSY_CYCLES)
  ) u_busy_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (data_acc),
    .busy   (busy)
  );

  assign dout     = {busy, 7'b0};
  assign fnumber  = fnumber_q;
  assign block    = block_q;
  assign multiple = multiple_q;
  assign keyon    = keyon_q;

endmodule

// File: tb/tb_sq_regif.sv
module tb_sq_regif;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs_n, wr_n, a0;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic [43:0] fnumber;
  logic [11:0] block;
  logic [15:0] multiple;
  logic [3:0]  keyon;

  sq_regif dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cs_n    (cs_n),
    .wr_n    (wr_n),
    .a0      (a0),
    .din     (din),
    .dout    (dout),
    .fnumber (fnumber),
    .block   (block),
    .multiple(multiple),
    .keyon   (keyon)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  dout;
    logic [43:0] fn;
    logic [11:0] blk;
    logic [15:0] mul;
    logic [3:0]  key;
  } snap_t;

  snap_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [43:0] exp_fn;
  logic [11:0] exp_blk;
  logic [15:0] exp_mul;
  logic [3:0]  exp_key;

  // Monitor: compares the DUT outputs against each queued expectation.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (dout !== e.dout || fnumber !== e.fn || block !== e.blk ||
            multiple !== e.mul || keyon !== e.key) begin
          errors++;
          $display("FAIL %s: got dout=%h fn=%h blk=%h mul=%h key=%b, want dout=%h fn=%h blk=%h mul=%h key=%b",
                   e.name, dout, fnumber, block, multiple, keyon,
                   e.dout, e.fn, e.blk, e.mul, e.key);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [7:0] d);
    snap_t s;
    s.name = name; s.dout = d; s.fn = exp_fn; s.blk = exp_blk;
    s.mul = exp_mul; s.key = exp_key;
    sb.push_back(s);
    @(negedge clk);
    #1;
  endtask

  // One strobe: sampled at the next edge, released and sampled idle at the one after.
  task automatic strobe(input logic a, input logic [7:0] d);
    cs_n = 1'b0; wr_n = 1'b0; a0 = a; din = d;
    tick();
    cs_n = 1'b1; wr_n = 1'b1;
    tick();
  endtask

  // Data write held low for 'hold' cycles; returns number of cycles busy was seen high.
  task automatic data_measure(input logic [7:0] d, input int hold, output int len);
    cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = d;
    len = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == hold - 1) begin
        cs_n = 1'b1; wr_n = 1'b1;
      end
      if (dout == 8'h80) len++;
      else break;
    end
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (dout == 8'h00) break;
      tick();
    end
    chk("idle_wait", int'(dout), 0);
  endtask

  initial begin
    int len;
    reset_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; din = 8'h00;
    exp_fn = '0; exp_blk = '0; exp_mul = '0; exp_key = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    push("reset_state", 8'h00);

    // High latch then low byte on channel 1
    strobe(1'b0, 8'hA5);
    strobe(1'b1, 8'h2B);
    push("fnh_no_effect", 8'h80);
    wait_idle();
    strobe(1'b0, 8'hA1);
    strobe(1'b1, 8'h7C);
    exp_fn[21:11] = 11'h37C;
    exp_blk[5:3]  = 3'd5;
    push("fnl_ch1", 8'h80);

    // Busy length and ignored write during busy
    wait_idle();
    strobe(1'b0, 8'h32);
    data_measure(8'h09, 1, len);
    chk("busy_len_mul", len, 32);
    exp_mul[11:8] = 4'h9;
    push("mul_ch2", 8'h00);
    strobe(1'b1, 8'h09);
    strobe(1'b1, 8'h05);
    push("mul_ignored_busy", 8'h80);

    // Long strobe gives a single event
    wait_idle();
    strobe(1'b0, 8'h28);
    data_measure(8'h13, 10, len);
    chk("busy_len_long_strobe", len, 32);
    exp_key = 4'b1000;
    push("keyon_ch3", 8'h00);

    // Write sampled on the last busy cycle is dropped
    wait_idle();
    strobe(1'b0, 8'h33);
    strobe(1'b1, 8'h0A);
    exp_mul[15:12] = 4'hA;
    repeat (30) tick();
    strobe(1'b1, 8'h06);
    push("last_busy_ignored", 8'h00);
    strobe(1'b1, 8'h05);
    exp_mul[15:12] = 4'h5;
    push("after_busy_accepted", 8'h80);

    // Reset in the middle of busy
    wait_idle();
    strobe(1'b0, 8'h30);
    strobe(1'b1, 8'h07);
    exp_mul[3:0] = 4'h7;
    push("mul_ch0", 8'h80);
    repeat (8) tick();
    reset_n = 1'b0;
    #1;
    chk("rst_async_dout", int'(dout), 0);
    exp_fn = '0; exp_blk = '0; exp_mul = '0; exp_key = '0;
    push("rst_clear", 8'h00);
    reset_n = 1'b1;
    tick();
    strobe(1'b1, 8'h55);
    push("post_rst_unmapped", 8'h80);
    wait_idle();
    strobe(1'b0, 8'h31);
    strobe(1'b1, 8'h06);
    exp_mul[7:4] = 4'h6;
    push("post_rst_mul_ch1", 8'h80);
    wait_idle();
    strobe(1'b1, 8'h0B);
    exp_mul[7:4] = 4'hB;
    push("addr_persist", 8'h80);

    repeat (3) tick();
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sq_regif.md
SQ_REGIF -- requirements
Module: sq_regif

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 32: number of clk cycles busy stays high after an accepted data write (range 1..255).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cs_n  input  1  chip select, active-low, synchronous to clk.
REQ-005 SHALL have port wr_n  input  1  write strobe, active-low, synchronous to clk.
REQ-006 SHALL have port a0  input  1  0 = address write, 1 = data write.
REQ-007 SHALL have port din  input  8  host write data.
REQ-008 SHALL have port dout  output  8  status: {busy, 7'b0}, always driven.
REQ-009 SHALL have port fnumber  output  44  4 channels x 11 bits, channel n at [11n+10:11n].
REQ-010 SHALL have port block  output  12  4 channels x 3 bits, channel n at [3n+2:3n].
REQ-011 SHALL have port multiple  output  16  4 channels x 4 bits, channel n at [4n+3:4n].
REQ-012 SHALL have port keyon  output  4  per-channel key state.

Function
REQ-013 SHALL register act = !cs_n && !wr_n each cycle; a write event SHALL be a cycle with act=1 and previous act=0 (one event per strobe, however long).
REQ-014 Address write event (a0=0) SHALL load din into the 8-bit address register, accepted regardless of busy.
REQ-015 Data write event (a0=1) SHALL be ignored entirely while busy=1, including the cycle busy is due to fall.
REQ-016 Accepted data write SHALL decode the address register: 0x30-0x33 -> multiple[ch]=din[3:0]; 0xA4-0xA7 -> hi-latch={din[5:3] block, din[2:0] fnum hi}; 0xA0-0xA3 -> fnumber[ch]={latch fnum hi, din}, block[ch]=latch block, atomically; 0x28 -> keyon[din[1:0]]=din[4]; ch = address[1:0].
REQ-017 The hi-latch SHALL be shared by all channels; a write to 0xA4-0xA7 SHALL NOT alter any output.
REQ-018 Writes to unmapped addresses SHALL change no output but SHALL still start busy.
REQ-019 Register updates SHALL take effect at the rising edge where the write event is sampled (visible the following cycle).
REQ-020 FSM states IDLE, BUSY: IDLE->BUSY on accepted data write, counter loaded with BUSY_CYCLES; BUSY decrements each cycle, BUSY->IDLE when counter reaches 1; busy=1 exactly BUSY_CYCLES cycles.
REQ-021 busy SHALL equal (state==BUSY), registered, no combinational path from inputs.
REQ-022 Address register SHALL persist across data writes (repeated data writes reuse it).

Reset
REQ-023 reset_n low SHALL asynchronously clear fnumber, block, multiple, keyon, hi-latch, address register, act history, counter to 0 and state to IDLE (dout=0x00).
REQ-024 Reset mid-BUSY SHALL abort busy immediately; first data write after release SHALL be accepted.

Structure
REQ-025 Package sq_pkg SHALL hold NCH=4, address constants (ADDR_KEYON=0x28, ADDR_MUL=0x30, ADDR_FNL=0xA0, ADDR_FNH=0xA4), default BUSY_CYCLES and the FSM state type.
REQ-026 Busy counter/FSM SHALL be one sub-module sq_busy_timer (start in, busy out); decode and storage stay in sq_regif.

Verification
REQ-027 Reset then no writes -> all outputs 0, dout=0x00.
REQ-028 Addr 0xA5, data 0x2B; wait busy low; addr 0xA1, data 0x7C -> fnumber[1]=0x37C, block[1]=5, other channels unchanged, fnumber[1] unchanged after first data write.
REQ-029 Data write to 0x32 with din=0x09 -> dout=0x80 for exactly 32 cycles, then 0x00; multiple[2]=9; second data write 0x05 issued during busy -> multiple[2] stays 9.
REQ-030 wr_n held low 10 cycles on addr 0x28 data 0x13 -> single write, keyon=4'b1000, busy 32 cycles not retriggered.
REQ-031 Data write 0x33 issued the cycle busy would fall -> ignored; repeat one cycle later -> accepted.
REQ-032 reset_n pulsed low at busy cycle 10 -> dout=0x00 at once, all registers 0, next write accepted.
